bcd_to_bin: RTL and testbench
=============================

# bcd_to_bin

Sequential decimal-to-binary converter: accepts a packed BCD number (one 4-bit digit per decade, most significant digit in the top nibble) and produces its 32-bit binary value. It accumulates one digit per clock using the multiply-by-10-and-add recurrence. It sits between the board's decimal entry path (switch banks / keypad digit latches) and the core's memory-mapped I/O register. It is the input-side counterpart of the binary-to-7-segment display path.

## Interface
Parameters:
- DIGITS, 6, number of BCD digits in i_bcd (1..9)
- W, 32, width of the binary result

Ports:
- i_clk  input  1  system clock; all state updates on rising edge
- i_rst_n  input  1  reset, synchronous, active-low
- i_start  input  1  conversion request; sampled only in IDLE
- i_bcd  input  4*DIGITS  packed BCD operand; digit k at bits [4k+3:4k]
- o_busy  output  1  high in CONV and DONE
- o_valid  output  1  one-cycle pulse: o_data (and o_err) updated this cycle
- o_data  output  W  binary result; held until the next o_valid
- o_err  output  1  invalid-digit flag, qualified by o_valid; tied 0 when BCD_ERR_CHECK_EN is undefined

## Operation
- States: IDLE, CONV, DONE.
- IDLE:
  - If i_start=1: latch i_bcd into an operand register, clear acc, set idx=DIGITS-1, go to CONV.
  - Otherwise remain in IDLE.
- CONV (one digit per cycle):
  - acc <= acc*10 + digit[idx], with acc*10 computed as (acc<<3)+(acc<<1).
  - Arithmetic is W bits wide and wraps modulo 2^W. No overflow flag; 999999999 fits in 30 bits.
  - If idx==0, go to DONE; otherwise idx <= idx-1.
- DONE:
  - o_data <= acc; o_valid=1 for exactly this cycle; go to IDLE.
- i_start is ignored in CONV and DONE; no queueing.
- i_bcd is sampled only at the start cycle. Later changes to i_bcd do not affect the running conversion.
- Reset (i_rst_n=0 at a clock edge): state=IDLE, acc=0, o_data=0, o_valid=0, o_busy=0, o_err=0. A reset during CONV aborts the conversion with no o_valid.
- Every reset value is 0.

## Timing
- Start accepted at edge t; CONV occupies edges t+1..t+DIGITS.
- o_valid is high in the cycle after edge t+DIGITS+1; latency is DIGITS+1 cycles (7 with the default).
- o_busy rises the cycle after the accepting edge and falls together with o_valid.
- Back-to-back throughput: one conversion every DIGITS+2 cycles, because the earliest next accepting edge is the one following DONE.

## Configuration
- Macro BCD_ERR_CHECK_EN.
- Defined:
  - Each digit is compared against 9 as it is consumed; a sticky error bit is cleared at start.
  - At DONE, if any digit was >9: o_err=1 and o_data <= 0. Otherwise o_err=0 and o_data <= acc.
- Undefined:
  - No check; o_err is constant 0.
  - Nibbles 10..15 are accumulated at face value. Example: nibble A in the thousands position contributes 10000.

## Structure
- Package bcd_pkg holds:
  - the state enum (IDLE/CONV/DONE)
  - constant BCD_DIGIT_MAX=4'd9
  - constant BCD_DIGIT_W=4
- Sub-module bcd_mac10 (combinational): computes acc_next = acc*10 + digit over W bits. Under the macro it also outputs digit_bad.

## Test plan
- i_bcd=24'h123456, single start -> o_valid exactly 7 cycles later; o_data=32'd123456 (0x0001E240); o_busy high for 7 cycles.
- i_bcd=24'h999999, then 24'h000000 back-to-back (second start asserted continuously) -> o_data=0x000F423F, then 0x00000000. Second o_valid 8 cycles after the first.
- i_start pulsed at CONV cycles 2 and 4 with a different i_bcd -> ignored: one o_valid, result from the original operand; i_bcd changed mid-conversion has no effect.
- i_bcd=24'h12A456:
  - with BCD_ERR_CHECK_EN: o_err=1, o_data=0
  - without it: o_err=0, o_data=32'd130456
- i_rst_n=0 for one edge at CONV cycle 3 of a 24'h654321 conversion -> next cycle o_busy=0, o_valid=0, o_data=0; no o_valid follows. A fresh start then yields 654321.
- DIGITS=1, W=8, i_bcd=4'h7 -> o_valid 2 cycles after start, o_data=8'd7.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter: FSM state encoding,
// digit geometry and the valid-digit limit.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         BCD_DIGIT_W   = 4;
  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  // A nibble above 9 is not a decimal digit.
  function automatic logic digit_is_bad(input logic [BCD_DIGIT_W-1:0] d);
    return d > BCD_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/bcd_to_bin_if.sv
// Request/result bundle between the decimal entry path and the converter.
// The master side drives the start request and the packed BCD operand;
// the slave side returns busy, the result strobe, the value and the error flag.
interface bcd_to_bin_if #(
  parameter int DIGITS = 6,
  parameter int W      = 32
);
  import bcd_pkg::*;

  logic                          i_start;
  logic [BCD_DIGIT_W*DIGITS-1:0] i_bcd;
  logic                          o_busy;
  logic                          o_valid;
  logic [W-1:0]                  o_data;
  logic                          o_err;

  modport master (
    output i_start,
    output i_bcd,
    input  o_busy,
    input  o_valid,
    input  o_data,
    input  o_err
  );

  modport slave (
    input  i_start,
    input  i_bcd,
    output o_busy,
    output o_valid,
    output o_data,
    output o_err
  );

endinterface

// File: rtl/bcd_mac10.sv
// One step of the decimal recurrence: acc_next = acc*10 + digit, modulo 2^W.
// The multiply by ten is built from two shifts so no multiplier is needed.
// With BCD_ERR_CHECK_EN defined it also flags a digit above 9.
module bcd_mac10
  import bcd_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0]           acc,
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [W-1:0]           acc_next
`ifdef BCD_ERR_CHECK_EN
  ,
  output logic                   digit_bad
`endif
);

  assign acc_next = (acc << 3) + (acc << 1) + W'(digit);

`ifdef BCD_ERR_CHECK_EN
  assign digit_bad = digit_is_bad(digit);
`endif

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter. One digit is consumed per clock,
// most significant first, so a DIGITS-digit operand needs DIGITS+1 cycles from
// the accepting edge to the result strobe. The operand is captured at start,
// so the entry path may change i_bcd freely while a conversion runs.
// Optional feature: define BCD_ERR_CHECK_EN to flag non-decimal nibbles
// (o_err=1, o_data=0); otherwise nibbles 10..15 are accumulated at face value.
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = 6,
  parameter int W      = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  bcd_to_bin_if.slave  bus
);

  localparam int                 OP_W     = BCD_DIGIT_W * DIGITS;
  localparam int                 IDX_W    = 4;
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(DIGITS - 1);

  state_t                  state;
  state_t                  state_next;
  logic                    load;
  logic                    step;
  logic                    finish;

  logic [OP_W-1:0]         operand;
  logic [IDX_W-1:0]        idx;
  logic [BCD_DIGIT_W-1:0]  digit;
  logic [W-1:0]            acc;
  logic [W-1:0]            acc_next;
  logic                    valid_q;
  logic [W-1:0]            data_q;

`ifdef BCD_ERR_CHECK_EN
  logic                    digit_bad;
  logic                    err_sticky;
  logic                    err_q;
`endif

  // State register; reset always returns to IDLE, aborting any conversion.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath strobes; start is only honoured in IDLE.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_start) begin
          load       = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        step = 1'b1;
        if (idx == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Select the digit addressed by idx from the captured operand.
  always_comb begin
    digit = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        digit = operand[k*BCD_DIGIT_W +: BCD_DIGIT_W];
      end
    end
  end

  bcd_mac10 #(
    .W (W)
  ) u_mac (
    .acc      (acc),
    .digit    (digit),
    .acc_next (acc_next)
`ifdef BCD_ERR_CHECK_EN
    ,
    .digit_bad(digit_bad)
`endif
  );

  // Operand capture, accumulation, digit index and result registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      operand    <= '0;
      acc        <= '0;
      idx        <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
`ifdef BCD_ERR_CHECK_EN
      err_sticky <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      valid_q <= finish;
      if (load) begin
        operand    <= bus.i_bcd;
        acc        <= '0;
        idx        <= IDX_LAST;
`ifdef BCD_ERR_CHECK_EN
        err_sticky <= 1'b0;
`endif
      end
      if (step) begin
        acc <= acc_next;
        if (idx != '0) begin
          idx <= idx - 1'b1;
        end
`ifdef BCD_ERR_CHECK_EN
        err_sticky <= err_sticky | digit_bad;
`endif
      end
      if (finish) begin
`ifdef BCD_ERR_CHECK_EN
        err_q  <= err_sticky;
        data_q <= err_sticky ? '0 : acc;
`else
        data_q <= acc;
`endif
      end
    end
  end

  assign bus.o_busy  = (state != IDLE);
  assign bus.o_valid = valid_q;
  assign bus.o_data  = data_q;
`ifdef BCD_ERR_CHECK_EN
  assign bus.o_err   = err_q;
`else
  assign bus.o_err   = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin. Expected values come from a decimal
// weighting model (sum of nibble * 10^position) rather than the recurrence.
// Honours BCD_ERR_CHECK_EN the same way the design does.
module tb_bcd_to_bin;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  bcd_to_bin_if #(.DIGITS(6), .W(32)) bus ();
  bcd_to_bin_if #(.DIGITS(1), .W(8))  sbus ();

  bcd_to_bin #(.DIGITS(6), .W(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  bcd_to_bin #(.DIGITS(1), .W(8)) dut_small (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: value = sum(nibble_k * 10^k) mod 2^32, error if any nibble > 9.
  function automatic void model(input logic [23:0] bcd, output logic [31:0] value,
                                output logic err);
    longint total;
    longint weight;
    total  = 0;
    weight = 1;
    err    = 1'b0;
    for (int k = 0; k < 6; k++) begin
      int nib;
      nib = int'(bcd[4*k +: 4]);
      if (nib > 9) err = 1'b1;
      total  = total + longint'(nib) * weight;
      weight = weight * 10;
    end
    value = 32'(total);
`ifdef BCD_ERR_CHECK_EN
    if (err) value = 32'd0;
`else
    err = 1'b0;
`endif
  endfunction

  task automatic wait_valid(input int budget, output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < budget) begin
      tick();
      cycles++;
      if (bus.o_valid === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.i_start  = 1'b0;
    bus.i_bcd    = '0;
    sbus.i_start = 1'b0;
    sbus.i_bcd   = '0;
    repeat (3) tick();
    n_checks++;
    if (bus.o_busy !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.o_busy); end
    n_checks++;
    if (bus.o_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_valid got=%b exp=0", bus.o_valid); end
    n_checks++;
    if (bus.o_data !== 32'd0) begin n_fails++; $display("[TB] FAIL reset_data got=%h exp=0", bus.o_data); end
    n_checks++;
    if (bus.o_err !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_err got=%b exp=0", bus.o_err); end
    n_checks++;
    if (sbus.o_data !== 8'd0 || sbus.o_valid !== 1'b0) begin
      n_fails++; $display("[TB] FAIL reset_small got data=%h valid=%b exp 0/0", sbus.o_data, sbus.o_valid);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [31:0] exp_v;
    logic        exp_e;
    int          cycles;
    int          busy_cnt;
    bit          seen;
    model(24'h123456, exp_v, exp_e);
    bus.i_bcd   = 24'h123456;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    busy_cnt = (bus.o_busy === 1'b1) ? 1 : 0;
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 20) begin
      tick();
      cycles++;
      if (bus.o_busy === 1'b1) busy_cnt++;
      if (bus.o_valid === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen || cycles != 7) begin n_fails++; $display("[TB] FAIL single_latency got=%0d seen=%0b exp=7", cycles, seen); end
    n_checks++;
    if (bus.o_data !== exp_v) begin n_fails++; $display("[TB] FAIL single_data got=%h exp=%h", bus.o_data, exp_v); end
    n_checks++;
    if (bus.o_err !== exp_e) begin n_fails++; $display("[TB] FAIL single_err got=%b exp=%b", bus.o_err, exp_e); end
    n_checks++;
    if (busy_cnt != 7) begin n_fails++; $display("[TB] FAIL single_busy_cycles got=%0d exp=7", busy_cnt); end
    tick();
    n_checks++;
    if (bus.o_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL single_valid_pulse got=%b exp=0", bus.o_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_v;
    logic        exp_e;
    int          c1;
    int          c2;
    bit          s1;
    bit          s2;
    bus.i_bcd   = 24'h999999;
    bus.i_start = 1'b1;
    tick();
    bus.i_bcd = 24'h000000;
    wait_valid(20, c1, s1);
    model(24'h999999, exp_v, exp_e);
    n_checks++;
    if (!s1 || c1 != 7) begin n_fails++; $display("[TB] FAIL b2b_first_latency got=%0d exp=7", c1); end
    n_checks++;
    if (bus.o_data !== exp_v) begin n_fails++; $display("[TB] FAIL b2b_first_data got=%h exp=%h", bus.o_data, exp_v); end
    wait_valid(20, c2, s2);
    bus.i_start = 1'b0;
    model(24'h000000, exp_v, exp_e);
    n_checks++;
    if (!s2 || c2 != 8) begin n_fails++; $display("[TB] FAIL b2b_interval got=%0d exp=8", c2); end
    n_checks++;
    if (bus.o_data !== exp_v || bus.o_err !== exp_e) begin
      n_fails++; $display("[TB] FAIL b2b_second_data got=%h/%b exp=%h/%b", bus.o_data, bus.o_err, exp_v, exp_e);
    end
    repeat (3) tick();
  endtask

  task automatic test_ignore_start();
    logic [31:0] exp_v;
    logic        exp_e;
    logic [31:0] got_v;
    int          n_valid;
    model(24'h246813, exp_v, exp_e);
    bus.i_bcd   = 24'h246813;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    n_valid = 0;
    got_v   = '0;
    tick();
    bus.i_start = 1'b1;
    bus.i_bcd   = 24'h999999;
    tick();
    bus.i_start = 1'b0;
    tick();
    bus.i_start = 1'b1;
    bus.i_bcd   = 24'h987654;
    tick();
    bus.i_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (bus.o_valid === 1'b1) begin
        n_valid++;
        got_v = bus.o_data;
      end
      tick();
    end
    n_checks++;
    if (n_valid != 1) begin n_fails++; $display("[TB] FAIL ignore_valid_count got=%0d exp=1", n_valid); end
    n_checks++;
    if (got_v !== exp_v) begin n_fails++; $display("[TB] FAIL ignore_data got=%h exp=%h", got_v, exp_v); end
  endtask

  task automatic test_invalid_digit();
    logic [31:0] exp_v;
    logic        exp_e;
    int          cycles;
    bit          seen;
    model(24'h12A456, exp_v, exp_e);
    bus.i_bcd   = 24'h12A456;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    wait_valid(20, cycles, seen);
    n_checks++;
    if (!seen || bus.o_data !== exp_v) begin
      n_fails++; $display("[TB] FAIL invalid_data got=%h seen=%0b exp=%h", bus.o_data, seen, exp_v);
    end
    n_checks++;
    if (bus.o_err !== exp_e) begin n_fails++; $display("[TB] FAIL invalid_err got=%b exp=%b", bus.o_err, exp_e); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] exp_v;
    logic        exp_e;
    int          n_valid;
    int          cycles;
    bit          seen;
    bus.i_bcd   = 24'h654321;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_data !== 32'd0) begin
      n_fails++;
      $display("[TB] FAIL abort_outputs got busy=%b valid=%b data=%h exp 0/0/0", bus.o_busy, bus.o_valid, bus.o_data);
    end
    n_valid = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.o_valid === 1'b1) n_valid++;
    end
    n_checks++;
    if (n_valid != 0) begin n_fails++; $display("[TB] FAIL abort_no_valid got=%0d exp=0", n_valid); end
    model(24'h654321, exp_v, exp_e);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    wait_valid(20, cycles, seen);
    n_checks++;
    if (!seen || cycles != 7 || bus.o_data !== exp_v) begin
      n_fails++; $display("[TB] FAIL abort_restart got=%h lat=%0d exp=%h lat=7", bus.o_data, cycles, exp_v);
    end
  endtask

  task automatic test_random();
    logic [23:0] bcd;
    logic [31:0] exp_v;
    logic        exp_e;
    int          cycles;
    bit          seen;
    for (int it = 0; it < 24; it++) begin
      for (int k = 0; k < 6; k++) bcd[4*k +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) bcd[4*$urandom_range(0, 5) +: 4] = 4'($urandom_range(10, 15));
      model(bcd, exp_v, exp_e);
      bus.i_bcd   = bcd;
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      bus.i_bcd   = 24'($urandom);
      wait_valid(20, cycles, seen);
      n_checks++;
      if (!seen || cycles != 7 || bus.o_data !== exp_v || bus.o_err !== exp_e) begin
        n_fails++;
        $display("[TB] FAIL random_%0d bcd=%h got=%h/%b lat=%0d exp=%h/%b lat=7",
                 it, bcd, bus.o_data, bus.o_err, cycles, exp_v, exp_e);
      end
    end
  endtask

  task automatic test_small();
    int         cycles;
    bit         seen;
    logic [7:0] exp_v;
    logic       exp_e;
    sbus.i_bcd   = 4'h7;
    sbus.i_start = 1'b1;
    tick();
    sbus.i_start = 1'b0;
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 10) begin
      tick();
      cycles++;
      if (sbus.o_valid === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen || cycles != 2) begin n_fails++; $display("[TB] FAIL small_latency got=%0d exp=2", cycles); end
    n_checks++;
    if (sbus.o_data !== 8'd7) begin n_fails++; $display("[TB] FAIL small_data got=%h exp=07", sbus.o_data); end
`ifdef BCD_ERR_CHECK_EN
    exp_v = 8'd0;
    exp_e = 1'b1;
`else
    exp_v = 8'd12;
    exp_e = 1'b0;
`endif
    tick();
    sbus.i_bcd   = 4'hC;
    sbus.i_start = 1'b1;
    tick();
    sbus.i_start = 1'b0;
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 10) begin
      tick();
      cycles++;
      if (sbus.o_valid === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen || sbus.o_data !== exp_v || sbus.o_err !== exp_e) begin
      n_fails++; $display("[TB] FAIL small_nibble_c got=%h/%b exp=%h/%b", sbus.o_data, sbus.o_err, exp_v, exp_e);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_start();
    test_invalid_digit();
    test_random();
    test_reset_abort();
    test_small();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
